// File: rtl/npc_mem_pkg.sv
// Shared memory-port types and helpers for the load/store and fetch initiators.
package npc_mem_pkg;

  localparam int unsigned MEM_DW = 64;
  localparam int unsigned MEM_BW = MEM_DW / 8;
  localparam int unsigned ADDR_W = 64;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} lsu_state_e;

  // Request fields that must survive past acceptance.
  typedef struct packed {
    logic      wen;
    logic [2:0] off;
    mem_size_e size;
    logic      sgn;
  } lsu_req_t;

  function automatic logic [MEM_BW-1:0] lane_mask(mem_size_e size, logic [2:0] off);
    logic [MEM_BW-1:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic misaligned(mem_size_e size, logic [2:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 64-bit doubleword port: store mask/shift and load shift/extend.
module mem_lane_align
  import npc_mem_pkg::*;
(
  input  mem_size_e         size,
  input  logic [2:0]        off,
  input  logic              sgn,
  input  logic [MEM_DW-1:0] wdata,
  input  logic [MEM_DW-1:0] rdata,
  output logic [MEM_BW-1:0] mask,
  output logic [MEM_DW-1:0] wdata_lane,
  output logic [MEM_DW-1:0] rdata_ext
);

  logic [5:0]        sh;
  logic [MEM_DW-1:0] wtrunc;
  logic [MEM_DW-1:0] rshift;

  assign sh         = {off, 3'b000};
  assign mask       = lane_mask(size, off);
  assign wdata_lane = wtrunc << sh;
  assign rshift     = rdata >> sh;

  // Drop store bits above the access size before they reach the lanes.
  always_comb begin
    wtrunc = wdata;
    case (size)
      SZ_B:    wtrunc = {56'b0, wdata[7:0]};
      SZ_H:    wtrunc = {48'b0, wdata[15:0]};
      SZ_W:    wtrunc = {32'b0, wdata[31:0]};
      default: wtrunc = wdata;
    endcase
  end

  always_comb begin
    rdata_ext = rshift;
    case (size)
      SZ_B:    rdata_ext = {{56{sgn & rshift[7]}},  rshift[7:0]};
      SZ_H:    rdata_ext = {{48{sgn & rshift[15]}}, rshift[15:0]};
      SZ_W:    rdata_ext = {{32{sgn & rshift[31]}}, rshift[31:0]};
      default: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator onto the 64-bit doubleword memory port.
module lsu_mem_master
  import npc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MEM_DW-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [MEM_DW-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [MEM_DW-1:0] mem_rd_data,
  input  logic              mem_rvalid,
  output logic              mem_we_en,
  output logic [ADDR_W-1:0] mem_we_addr,
  output logic [MEM_DW-1:0] mem_we_data,
  output logic [MEM_BW-1:0] mem_we_mask,
  input  logic              mem_ready
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_e        state;
  lsu_req_t          lat;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              timeout_hit;

  mem_size_e         al_size;
  logic [2:0]        al_off;
  logic              al_sgn;
  logic [MEM_BW-1:0] al_mask;
  logic [MEM_DW-1:0] al_wdata;
  logic [MEM_DW-1:0] al_rdata;
  logic [ADDR_W-1:0] dw_addr;

  // Store lanes are computed from the incoming request at acceptance; load extraction uses the latch.
  assign al_size = (state == IDLE) ? mem_size_e'(req_size) : lat.size;
  assign al_off  = (state == IDLE) ? req_addr[2:0] : lat.off;
  assign al_sgn  = lat.sgn;
  assign dw_addr = {req_addr[ADDR_W-1:3], 3'b000};

  assign cnt_inc     = cnt + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  mem_lane_align u_align (
    .size       (al_size),
    .off        (al_off),
    .sgn        (al_sgn),
    .wdata      (req_wdata),
    .rdata      (mem_rd_data),
    .mask       (al_mask),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat         <= '0;
      cnt         <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_we_en   <= 1'b0;
      mem_we_addr <= '0;
      mem_we_data <= '0;
      mem_we_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat       <= '{wen: req_wen, off: req_addr[2:0], size: al_size, sgn: req_signed};
            req_ready <= 1'b0;
            if (misaligned(al_size, req_addr[2:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_rd_en <= ~req_wen;
              mem_we_en <= req_wen;
              if (req_wen) begin
                mem_we_addr <= dw_addr;
                mem_we_mask <= al_mask;
                mem_we_data <= al_wdata;
              end else begin
                mem_rd_addr <= dw_addr;
              end
            end
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          if (mem_ready) begin
            mem_rd_en <= 1'b0;
            mem_we_en <= 1'b0;
            if (lat.wen) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              state <= WAIT_R;
            end
          end else if (timeout_hit) begin
            mem_rd_en  <= 1'b0;
            mem_we_en  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        WAIT_R: begin
          cnt <= cnt_inc;
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= al_rdata;
          end else if (timeout_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a spec-level access model.
module tb_lsu_mem_master;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_rvalid;
  logic        mem_we_en;
  logic [63:0] mem_we_addr;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;
  logic        mem_ready;

  int tests_run;
  int tests_failed;

  lsu_mem_master #(.TIMEOUT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_rvalid  (mem_rvalid),
    .mem_we_en   (mem_we_en),
    .mem_we_addr (mem_we_addr),
    .mem_we_data (mem_we_data),
    .mem_we_mask (mem_we_mask),
    .mem_ready   (mem_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on size in bytes and lane offset.
  function automatic logic [63:0] size_bits(int nb);
    if (nb >= 8) return '1;
    return (64'd1 << (8 * nb)) - 64'd1;
  endfunction

  function automatic logic [63:0] exp_load(logic [63:0] raw, logic [63:0] addr, int size, bit sgn);
    int          nb = 1 << size;
    int          off = int'(addr % 8);
    logic [63:0] m = size_bits(nb);
    logic [63:0] v = (raw >> (8 * off)) & m;
    if (sgn && nb < 8 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] exp_mask(logic [63:0] addr, int size);
    int nb = 1 << size;
    int off = int'(addr % 8);
    return 8'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [63:0] exp_wdata(logic [63:0] wdata, logic [63:0] addr, int size);
    int off = int'(addr % 8);
    return (wdata & size_bits(1 << size)) << (8 * off);
  endfunction

  // Runs one request from a negedge in IDLE to the negedge after its response handshake.
  task automatic do_access(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input int size, input bit sgn, input logic [63:0] rdata,
                           input int rdy_dly, input int rv_dly, input int resp_dly);
    int          nb = 1 << size;
    bit          mis = (addr % 64'(nb)) != 0;
    logic [63:0] base = addr & ~64'h7;
    logic [63:0] exp_rd = (mis || wen) ? 64'h0 : exp_load(rdata, addr, size, sgn);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_size   = 2'(size);
    req_signed = sgn;
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    if (!mis) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        check("resp_valid_in_req", 64'(resp_valid), 64'd0);
        check("rd_en_req", 64'(mem_rd_en), 64'(!wen));
        check("we_en_req", 64'(mem_we_en), 64'(wen));
        if (wen) begin
          check("we_addr", mem_we_addr, base);
          check("we_mask", 64'(mem_we_mask), 64'(exp_mask(addr, size)));
          check("we_data", mem_we_data, exp_wdata(wdata, addr, size));
        end else begin
          check("rd_addr", mem_rd_addr, base);
        end
        mem_ready   = (k == rdy_dly);
        mem_rvalid  = !wen && ($urandom_range(0, 1) == 1);
        mem_rd_data = {$urandom, $urandom};
        @(negedge clock);
      end
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (!wen) begin
        for (int j = 0; j <= rv_dly; j++) begin
          check("rd_en_wait", 64'(mem_rd_en), 64'd0);
          check("resp_valid_in_wait", 64'(resp_valid), 64'd0);
          mem_rvalid  = (j == rv_dly);
          mem_rd_data = (j == rv_dly) ? rdata : {$urandom, $urandom};
          mem_ready   = ($urandom_range(0, 1) == 1);
          @(negedge clock);
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b0;
      end
    end
    for (int r = 0; r <= resp_dly; r++) begin
      check("resp_valid", 64'(resp_valid), 64'd1);
      check("resp_err", 64'(resp_err), 64'(mis));
      check("resp_rdata", resp_rdata, exp_rd);
      check("en_in_resp", 64'({mem_rd_en, mem_we_en}), 64'd0);
      resp_ready = (r == resp_dly);
      @(negedge clock);
    end
    resp_ready = 1'b0;
    check("resp_valid_after", 64'(resp_valid), 64'd0);
    check("req_ready_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clock        = 1'b0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = '0;
    req_signed   = 1'b0;
    resp_ready   = 1'b0;
    mem_rd_data  = '0;
    mem_rvalid   = 1'b0;
    mem_ready    = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_mem_en", 64'({mem_rd_en, mem_we_en}), 64'd0);
    check("rst_mem_addr", mem_rd_addr | mem_we_addr, 64'd0);
    check("rst_mem_wdata", mem_we_data, 64'd0);
    check("rst_mem_mask", 64'(mem_we_mask), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed accesses.
    do_access(1'b1, 64'h8000_0003, 64'hAB, 0, 1'b0, 64'h0, 0, 0, 0);
    do_access(1'b0, 64'h8000_0006, 64'h0, 1, 1'b1, 64'h8001_0000_0000_0000, 0, 0, 0);
    check("lh_signed_const", exp_load(64'h8001_0000_0000_0000, 64'h8000_0006, 1, 1'b1),
          64'hFFFF_FFFF_FFFF_8001);
    do_access(1'b0, 64'h8000_0006, 64'h0, 1, 1'b0, 64'h8001_0000_0000_0000, 0, 0, 0);
    do_access(1'b0, 64'h8000_0002, 64'h0, 2, 1'b0, 64'h0, 0, 0, 0);
    do_access(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 3, 1'b0, 64'h0, 3, 0, 2);

    // Load timeout: accepted by memory, read data never returns.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0020; req_size = 2'd3; req_signed = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    check("to_ld_rd_en", 64'(mem_rd_en), 64'd1);
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      check("to_ld_pending", 64'(resp_valid), 64'd0);
      @(negedge clock);
    end
    check("to_ld_valid", 64'(resp_valid), 64'd1);
    check("to_ld_err", 64'(resp_err), 64'd1);
    check("to_ld_rdata", resp_rdata, 64'd0);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;

    // Store timeout: memory never accepts.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0028; req_wdata = 64'h55; req_size = 2'd2;
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("to_st_we_en", 64'(mem_we_en), 64'd1);
      check("to_st_pending", 64'(resp_valid), 64'd0);
      @(negedge clock);
    end
    check("to_st_we_off", 64'(mem_we_en), 64'd0);
    check("to_st_err", 64'({resp_valid, resp_err}), 64'd3);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    do_access(1'b0, 64'h8000_0030, 64'h0, 2, 1'b1, 64'h1234_5678_F000_0001, 1, 2, 1);

    // Reset while a read request is being driven: enable must drop without a clock edge.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0040; req_size = 2'd3;
    @(negedge clock);
    req_valid = 1'b0;
    check("rst_req_rd_en_before", 64'(mem_rd_en), 64'd1);
    #2 reset = 1'b1;
    #1 check("rst_req_rd_en_async", 64'(mem_rd_en), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_req_no_resp", 64'(resp_valid), 64'd0);

    // Reset while waiting for read data.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0048; req_size = 2'd3;
    @(negedge clock);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1 check("rst_wait_en", 64'({mem_rd_en, mem_we_en}), 64'd0);
    check("rst_wait_resp", 64'(resp_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_wait_no_resp", 64'(resp_valid), 64'd0);
    do_access(1'b0, 64'h8000_0008, 64'h0, 3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0);

    // Random mix of sizes, offsets, directions and handshake delays.
    for (int n = 0; n < 60; n++) begin
      int          sz = $urandom_range(0, 3);
      logic [63:0] a = {32'h8000_0000, $urandom} ;
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      do_access($urandom_range(0, 1) == 1, a, {$urandom, $urandom}, sz, $urandom_range(0, 1) == 1,
                {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that converts one pipeline memory request (byte/half/word/double, load or store) into a single access on the 64-bit doubleword memory port served by the simulation memory model. It sits between the execute/memory stage and memory. It aligns addresses, generates byte write masks, shifts store data into the correct lanes, extracts and sign-/zero-extends load data, and reports misalignment and timeout errors. Only one request is in flight at a time.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ plus WAIT_R before an error response; 0 disables the timeout.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request; high only in IDLE.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-justified.
- `req_size` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `req_signed` in 1: sign-extend load data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned request or timeout.
- `mem_rd_en` out 1: read request.
- `mem_rd_addr` out 64: doubleword-aligned read address.
- `mem_rd_data` in 64: read data, valid with `mem_rvalid`.
- `mem_rvalid` in 1: read data valid.
- `mem_we_en` out 1: write request.
- `mem_we_addr` out 64: doubleword-aligned write address.
- `mem_we_data` out 64: lane-shifted write data.
- `mem_we_mask` out 8: byte-enable mask.
- `mem_ready` in 1: memory accepts the enabled request this cycle.

## Operation
- States are IDLE, REQ, WAIT_R and RESP. Reset forces IDLE.
- **IDLE**
  - When `req_valid` is high, latch the request.
  - If the request is misaligned (`req_addr % (1<<req_size) != 0`), go to RESP with err=1 and issue no memory access.
  - Otherwise, clear the timeout counter and go to REQ.
- **REQ**
  - Drive exactly one of `mem_rd_en` or `mem_we_en`. All mem outputs stay stable until `mem_ready` is high.
  - Address is `addr & ~7`.
  - Mask is `((1<<(1<<size))-1) << addr[2:0]`.
  - Data is `wdata << (8*addr[2:0])`; bits above the access size are zeroed before shifting.
  - A store with `mem_ready` high goes to RESP with err=0.
  - A load with `mem_ready` high goes to WAIT_R. `mem_rvalid` is ignored in REQ.
- **WAIT_R**
  - Enables are low.
  - On `mem_rvalid`, register `(mem_rd_data >> 8*addr[2:0])`, truncate it to the access size, extend it per `req_signed`, then go to RESP.
- **Timeout**
  - The counter increments on every cycle spent in REQ or WAIT_R.
  - When it reaches `TIMEOUT` (nonzero), go to RESP with err=1 and rdata=0, and deassert the enables.
- **RESP**
  - `resp_valid` is held with stable data until `resp_ready` is high; then go to IDLE.
  - A new request is accepted on the cycle after the handshake, never in the same cycle.
- Size D is always aligned when `addr[2:0]==0`; its mask is 0xFF.
- `mem_rvalid` or `mem_ready` arriving in any other state is ignored.

## Timing
- Reset values:
  - `resp_valid`, `resp_err` and `resp_rdata` are 0.
  - All `mem_*` outputs are 0.
  - `req_ready` is 1, since the state is IDLE.
- `req_ready`, enables, addresses, mask and write data are decoded from registered state only. There is no combinational path from `req_*` to `mem_*`.
- Minimum latency, counting the acceptance cycle as T0:
  - Store: `resp_valid` at T2.
  - Load: `resp_valid` at T3, with `mem_ready` at T1 and `mem_rvalid` at T2.
  - Misaligned: `resp_valid` at T1.
- Reset mid-operation aborts immediately:
  - Enables drop asynchronously and no response is produced.
  - Latched request and counter are cleared.

## Structure
- Shared package `npc_mem_pkg` holds:
  - `mem_size_e` (B/H/W/D).
  - `lsu_state_e`.
  - `MEM_DW = 64`.
  - A function for the mask computation.
- Sub-module `mem_lane_align` is purely combinational and performs mask generation, store shift, and load shift/truncate/extend. It is shared with the future fetch unit.
- `lsu_mem_master` holds the FSM, request latch, timeout counter and response register.

## Test plan
- **SB**: addr 0x8000_0003, wdata 0xAB, `mem_ready`=1 → at T1 `mem_we_addr`=0x8000_0000, mask=0x08, data=0x0000_0000_AB00_0000; `resp_valid` at T2 with err=0.
- **LH signed**: addr 0x8000_0006, `mem_rd_data`=0x8001_0000_0000_0000 → `resp_rdata`=0xFFFF_FFFF_FFFF_8001. The same access unsigned → 0x0000_0000_0000_8001.
- **LW misaligned**: addr 0x8000_0002 → `mem_rd_en` never asserts; `resp_valid` at T1 with err=1 and rdata=0.
- **SD with `mem_ready` delayed 3 cycles** → mem outputs stable for 4 cycles, mask 0xFF. Hold `resp_ready` low for 2 cycles → response held stable.
- **Timeout**: `TIMEOUT`=8, load with `mem_ready`=1 and `mem_rvalid` never asserted → err=1 after 8 cycles in REQ+WAIT_R; a later request completes normally.
- **Reset asserted in WAIT_R** → enables 0 in the same cycle, no `resp_valid`; after release, an LD at 0x8000_0008 returns the full `mem_rd_data`.
